// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg -- shared types and constants for the serial link controller
// Rev 1.0
// ============================================================================
package serial_pkg;

  localparam int BYTE_W         = 8;
  localparam int IDX_W          = 2;
  localparam int DEF_TIMEOUT    = 1_000_000;
  localparam int DEF_GAP_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter -- combinational round-robin pick of the first request at or
// after the pointer. Rev 1.0
// ============================================================================
module rr_arbiter
  import serial_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [3:0]       w_req_ext;
  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    w_req_ext            = '0;
    w_req_ext[NREQ-1:0]  = req_i;
    w_cand               = '0;
    valid_o              = 1'b0;
    idx_o                = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (w_req_ext[w_cand]) begin
        valid_o = 1'b1;
        idx_o   = w_cand;
      end
    end
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = valid_o && (idx_o == IDX_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_link_ctrl.sv
`default_nettype none
// ============================================================================
// serial_link_ctrl -- round-robin TX sequencer with watchdog and inter-char
// gap, plus a one-deep RX holding register with sticky overrun. Rev 1.0
// ============================================================================
module serial_link_ctrl
  import serial_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_load,
  output logic                   tx_enable,
  input  logic                   char_sent,
  input  logic                   char_received,
  input  logic [BYTE_W-1:0]      rx_data,
  output logic [BYTE_W-1:0]      rx_byte,
  output logic                   rx_valid,
  input  logic                   rx_pop,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id
);

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d, grant_q, grant_d;
  logic [BYTE_W-1:0]  txd_q, txd_d;
  logic [NREQ-1:0]    ack_q, ack_d, err_q, err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BYTE_W-1:0]  rx_byte_q, rx_byte_d;
  logic               rx_valid_q, rx_valid_d, overrun_q, overrun_d;

  logic [NREQ-1:0]    w_grant, w_gnt_onehot;
  logic [IDX_W-1:0]   w_gnt_idx, w_next_ptr;
  logic               w_any, w_ovr_set;
  logic [BYTE_W-1:0]  w_sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_q),
    .grant_o (w_grant),
    .idx_o   (w_gnt_idx),
    .valid_o (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_sel_data = req_data[i*BYTE_W +: BYTE_W];
      w_gnt_onehot[i] = (grant_q == IDX_W'(i));
    end
    w_next_ptr = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    txd_d     = txd_q;
    ack_d     = '0;
    err_d     = '0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    tx_load   = 1'b0;
    tx_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          grant_d = w_gnt_idx;
          txd_d   = w_sel_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_load   = 1'b1;
        tx_enable = 1'b1;
        to_cnt_d  = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        tx_enable = 1'b1;
        to_cnt_d  = to_cnt_q + TO_W'(1);
        // A completion on the watchdog's last cycle still counts as success.
        if (char_sent || (to_cnt_q == TO_LAST)) begin
          if (char_sent) ack_d = w_gnt_onehot;
          else           err_d = w_gnt_onehot;
          rr_d      = w_next_ptr;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d   = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      txd_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      txd_q     <= txd_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // First byte wins on overrun; a same-cycle pop frees the slot for the new byte.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    w_ovr_set  = char_received && rx_valid_q && !rx_pop;
    if (char_received && (!rx_valid_q || rx_pop)) begin
      rx_byte_d  = rx_data;
      rx_valid_d = 1'b1;
    end else if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
    if (w_ovr_set && !(overrun_clr && !rx_valid_d)) overrun_d = 1'b1;
    else if (overrun_clr)                           overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign tx_data  = txd_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule
`default_nettype wire
